pe_row_ctrl: RTL and testbench
==============================

PE_ROW_CTRL -- requirements
Module: pe_row_ctrl

Interface
REQ-001 SHALL have parameters: LANES, default 16, number of PE lanes; ACC_W, default 24, accumulator width; LEN_W, default 8, job length width.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst  in  1  synchronous, active-low reset.
REQ-004 SHALL have ports: start  in  1  job request (sampled in IDLE); mode_in  in  2  job mode; len  in  LEN_W  pixel beats per job.
REQ-005 SHALL have ports: busy  out  1  job active; done  out  1  one-cycle job-complete pulse.
REQ-006 SHALL have ports: w_valid  in  1; w_data  in  8 x LANES  full-row weights; w_ready  out  1.
REQ-007 SHALL have ports: px_valid  in  1  upstream pixel beat valid; px_ready  out  1  beat accepted when both high.
REQ-008 SHALL have ports: mode_out  out  2  row mode; weight_out  out  8 x LANES  row weights; pe_en  out  1  pixel beat presented to row this cycle.
REQ-009 SHALL have ports: product  in  signed 16 x LANES  row products; psum  out  signed ACC_W x LANES; psum_valid  out  1; psum_ready  in  1.

Function
REQ-010 SHALL implement FSM IDLE, LOAD_W, STREAM, DRAIN, OUT.
REQ-011 IDLE: start=1 with len!=0 -> latch mode_in, len; clear accumulators; go LOAD_W. start with len=0 -> done pulse next cycle, stay IDLE.
REQ-012 LOAD_W: w_ready=1; on w_valid -> register w_data into weight_out; go STREAM.
REQ-013 STREAM: px_ready=1; each accepted beat asserts pe_en the same cycle and increments beat counter; on beat number len -> go DRAIN.
REQ-014 Row product for a beat SHALL be taken exactly one cycle after that beat's pe_en; accumulate lane-wise with sign extension.
REQ-015 Accumulation SHALL saturate to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; no wrap.
REQ-016 DRAIN: one cycle, absorbs final product; go OUT.
REQ-017 OUT: psum_valid=1, psum held stable; on psum_ready -> done=1 same cycle, go IDLE.
REQ-018 px_valid gaps in STREAM SHALL stall without counting or accumulating; product sampled only one cycle after pe_en=1.
REQ-019 mode_out and weight_out SHALL change only on leaving IDLE / in LOAD_W respectively; stable for the whole job.
REQ-020 start while busy=1 SHALL be ignored.
REQ-021 busy=1 in every state except IDLE.
REQ-022 Job latency (no stalls, immediate w_valid/psum_ready): start to done = len + 4 cycles.

Reset
REQ-023 rst=0 at a clock edge SHALL force IDLE, abort any job, no done pulse.
REQ-024 Reset values: busy, done, w_ready, px_ready, pe_en, psum_valid = 0; mode_out = 0; weight_out = 0; psum = 0; counters = 0.

Structure
REQ-025 Shared package pe_ctrl_pkg SHALL hold the FSM state enum, LANES/ACC_W/LEN_W defaults, and the saturating-add function.
REQ-026 One sub-module, pe_acc_lane (single-lane saturating accumulator with clear/enable), SHALL be instantiated LANES times.

Verification
REQ-027 len=4, weights all 1, product lane i = i each beat, no stalls -> psum[i]=4*i, done 8 cycles after start.
REQ-028 len=3, px_valid toggled 1,0,1,0,1 -> exactly 3 pe_en pulses, psum = sum of 3 sampled products.
REQ-029 product lane 0 = 32767 for len=255 -> psum[0] = 8355585 (no saturation); repeat with ACC_W=20 -> psum[0] = 524287.
REQ-030 psum_ready held 0 for 10 cycles in OUT -> psum stable, psum_valid=1, done only on first cycle psum_ready=1.
REQ-031 rst=0 mid-STREAM -> next cycle IDLE, all outputs at reset values, no done; new job then completes correctly.
REQ-032 start with len=0 -> done pulse next cycle, w_ready never asserted; start during busy ignored.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// Shared types, default sizes and the saturating accumulate used by the PE row controller.
package pe_ctrl_pkg;

    localparam int unsigned DEF_LANES = 16;
    localparam int unsigned DEF_ACC_W = 24;
    localparam int unsigned DEF_LEN_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        OUT
    } state_t;

    // Signed add clamped to the range of a two's-complement value of 'width' bits (width <= 62).
    function automatic longint sat_add(input longint a, input longint b, input int unsigned width);
        longint sum;
        longint hi;
        longint lo;
        sum = a + b;
        hi  = (longint'(1) <<< (width - 1)) - 1;
        lo  = -hi - 1;
        if (sum > hi) begin
            return hi;
        end
        if (sum < lo) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/pe_row_ctrl_acc_lane.sv
// Single-lane saturating accumulator with synchronous clear and enable.
module pe_acc_lane
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned ACC_W = DEF_ACC_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    en,
    input  logic signed [15:0]      product,
    output logic signed [ACC_W-1:0] acc
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= ACC_W'(sat_add(longint'(acc), longint'(product), ACC_W));
        end
    end

endmodule

// File: rtl/pe_row_ctrl.sv
// Job controller for one PE row: loads weights, streams pixel beats and accumulates
// lane-wise row products into saturating partial sums.
module pe_row_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int unsigned LANES = DEF_LANES,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [1:0]                    mode_in,
    input  logic [LEN_W-1:0]              len,
    output logic                          busy,
    output logic                          done,
    input  logic                          w_valid,
    input  logic [8*LANES-1:0]            w_data,
    output logic                          w_ready,
    input  logic                          px_valid,
    output logic                          px_ready,
    output logic [1:0]                    mode_out,
    output logic [8*LANES-1:0]            weight_out,
    output logic                          pe_en,
    input  logic signed [16*LANES-1:0]    product,
    output logic signed [ACC_W*LANES-1:0] psum,
    output logic                          psum_valid,
    input  logic                          psum_ready
);

    state_t             state;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic               pe_en_d;
    logic               clear;

    assign pe_en = px_ready & px_valid;
    assign clear = (state == IDLE) && start && (len != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            len_q      <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            w_ready    <= 1'b0;
            px_ready   <= 1'b0;
            psum_valid <= 1'b0;
            mode_out   <= '0;
            weight_out <= '0;
            pe_en_d    <= 1'b0;
        end else begin
            done    <= 1'b0;
            pe_en_d <= pe_en;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            mode_out <= mode_in;
                            len_q    <= len;
                            cnt      <= '0;
                            busy     <= 1'b1;
                            w_ready  <= 1'b1;
                            state    <= LOAD_W;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                LOAD_W: begin
                    if (w_valid) begin
                        weight_out <= w_data;
                        w_ready    <= 1'b0;
                        px_ready   <= 1'b1;
                        state      <= STREAM;
                    end
                end
                STREAM: begin
                    if (px_valid) begin
                        cnt <= cnt + LEN_W'(1);
                        if ((cnt + LEN_W'(1)) == len_q) begin
                            px_ready <= 1'b0;
                            state    <= DRAIN;
                        end
                    end
                end
                // The last beat's product arrives here and is absorbed via pe_en_d.
                DRAIN: begin
                    psum_valid <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (psum_ready) begin
                        psum_valid <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        pe_acc_lane #(.ACC_W(ACC_W)) u_lane (
            .clk     (clk),
            .rst     (rst),
            .clear   (clear),
            .en      (pe_en_d),
            .product (product[16*i +: 16]),
            .acc     (psum[ACC_W*i +: ACC_W])
        );
    end

endmodule

// File: tb/tb_pe_row_ctrl.sv
// Directed self-checking bench for pe_row_ctrl (16-lane/24-bit instance plus a 2-lane/20-bit one).
module tb_pe_row_ctrl;

    logic         clk;
    logic         rst;
    logic         start;
    logic [1:0]   mode_in;
    logic [7:0]   len;
    logic         w_valid;
    logic         px_valid;
    logic         psum_ready;

    logic         busy, done, w_ready, px_ready, pe_en, psum_valid;
    logic [1:0]   mode_out;
    logic [127:0] w_data, weight_out;
    logic [255:0] product;
    logic [383:0] psum;

    logic         busy20, done20, w_ready20, px_ready20, pe_en20, psum_valid20;
    logic [1:0]   mode_out20;
    logic [15:0]  w_data20, weight_out20;
    logic [31:0]  product20;
    logic [39:0]  psum20;

    int checks;
    int failures;
    int pe_count;
    int wr_count;

    pe_row_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .mode_in(mode_in), .len(len),
        .busy(busy), .done(done), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
        .px_valid(px_valid), .px_ready(px_ready), .mode_out(mode_out), .weight_out(weight_out),
        .pe_en(pe_en), .product(product), .psum(psum), .psum_valid(psum_valid),
        .psum_ready(psum_ready)
    );

    pe_row_ctrl #(.LANES(2), .ACC_W(20), .LEN_W(8)) u_dut20 (
        .clk(clk), .rst(rst), .start(start), .mode_in(mode_in), .len(len),
        .busy(busy20), .done(done20), .w_valid(w_valid), .w_data(w_data20), .w_ready(w_ready20),
        .px_valid(px_valid), .px_ready(px_ready20), .mode_out(mode_out20),
        .weight_out(weight_out20), .pe_en(pe_en20), .product(product20), .psum(psum20),
        .psum_valid(psum_valid20), .psum_ready(psum_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pe_en) pe_count++;
        if (w_ready) wr_count++;
    end

    function automatic logic signed [63:0] lane(input int i);
        return $signed(psum[i*24 +: 24]);
    endfunction

    function automatic logic signed [63:0] lane20(input int i);
        return $signed(psum20[i*20 +: 20]);
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_prod(input int i, input int v);
        product[i*16 +: 16] = 16'(v);
    endtask

    // Starts a job at the current negedge and steps until done or the cycle budget runs out.
    task automatic run_job(input int ln, input logic [1:0] md, input logic [31:0] pat,
                           input bit ramp, input int restart_at, input int max_cyc,
                           output int done_at, output int beats, output int wr);
        int pe0;
        int wr0;
        pe0 = pe_count;
        wr0 = wr_count;
        done_at = -1;
        start = 1'b1;
        len = 8'(ln);
        mode_in = md;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            start   = (k == restart_at);
            len     = (k == restart_at) ? 8'd7 : 8'(ln);
            mode_in = (k == restart_at) ? 2'd3 : md;
            if (done) begin
                done_at = k;
                break;
            end
            px_valid = (k >= 2 && k - 2 < 32) ? pat[k-2] : 1'b1;
            if (ramp) begin
                set_prod(0, 10 * k);
                set_prod(1, -k);
            end
        end
        beats = pe_count - pe0;
        wr = wr_count - wr0;
    endtask

    initial begin
        int d;
        int b;
        int w;
        int found;
        checks = 0;
        failures = 0;
        pe_count = 0;
        wr_count = 0;
        rst = 1'b0;
        start = 1'b0;
        mode_in = '0;
        len = '0;
        w_valid = 1'b0;
        px_valid = 1'b0;
        psum_ready = 1'b0;
        w_data = '0;
        w_data20 = '0;
        product = '0;
        product20 = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_px_ready", px_ready, 0);
        chk("rst_pe_en", pe_en, 0);
        chk("rst_psum_valid", psum_valid, 0);
        chk("rst_mode_out", mode_out, 0);
        chk("rst_weight_nz", weight_out != '0, 0);
        chk("rst_psum0", lane(0), 0);
        rst = 1'b1;
        @(negedge clk);

        // Basic job: len=4, weights 1, product lane i = i.
        for (int i = 0; i < 16; i++) begin
            w_data[i*8 +: 8] = 8'h01;
            set_prod(i, i);
        end
        w_valid = 1'b1;
        px_valid = 1'b1;
        psum_ready = 1'b1;
        run_job(4, 2'd2, '1, 1'b0, 0, 40, d, b, w);
        chk("t1_done_at", d, 8);
        chk("t1_beats", b, 4);
        chk("t1_mode_out", mode_out, 2);
        chk("t1_weight_ok", weight_out == {16{8'h01}}, 1);
        for (int i = 0; i < 16; i++) chk($sformatf("t1_psum%0d", i), lane(i), 4 * i);
        chk("t1_busy_after", busy, 0);

        // Stalled stream: px_valid 1,0,1,0,1, ramped products sampled a cycle after pe_en.
        run_job(3, 2'd1, 32'hFFFF_FFF5, 1'b1, 0, 40, d, b, w);
        chk("t2_done_at", d, 9);
        chk("t2_beats", b, 3);
        chk("t2_psum0", lane(0), 150);
        chk("t2_psum1", lane(1), -15);
        chk("t2_psum2", lane(2), 6);

        // Long job near the accumulator limits, plus the 20-bit instance saturating.
        for (int i = 0; i < 16; i++) set_prod(i, 0);
        set_prod(0, 32767);
        set_prod(1, -32768);
        product20 = {16'h8000, 16'h7FFF};
        w_data20 = 16'h0101;
        px_valid = 1'b1;
        run_job(255, 2'd1, '1, 1'b0, 0, 300, d, b, w);
        chk("t3_done_at", d, 259);
        chk("t3_beats", b, 255);
        chk("t3_psum0", lane(0), 8355585);
        chk("t3_psum1", lane(1), -8355840);
        chk("t3_done20", done20, 1);
        chk("t3_psum20_0", lane20(0), 524287);
        chk("t3_psum20_1", lane20(1), -524288);
        chk("t3_weight20", weight_out20, 16'h0101);
        chk("t3_mode20", mode_out20, 1);
        chk("t3_idle20", {busy20, w_ready20, px_ready20, pe_en20, psum_valid20}, 0);

        // Start while busy is ignored.
        run_job(3, 2'd1, '1, 1'b0, 3, 40, d, b, w);
        chk("t4_done_at", d, 7);
        chk("t4_beats", b, 3);
        chk("t4_mode_out", mode_out, 1);
        @(negedge clk);
        chk("t4_no_restart", busy, 0);

        // Zero-length job: immediate done, no weight handshake.
        run_job(0, 2'd3, '1, 1'b0, 0, 10, d, b, w);
        chk("t5_done_at", d, 1);
        chk("t5_w_ready_seen", w, 0);
        chk("t5_busy", busy, 0);
        @(negedge clk);
        chk("t5_done_once", done, 0);

        // Output back-pressure: psum held while psum_ready stays low.
        set_prod(0, 5);
        psum_ready = 1'b0;
        start = 1'b1;
        len = 8'd2;
        mode_in = 2'd0;
        found = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (psum_valid) begin
                found = k;
                break;
            end
        end
        chk("t6_out_at", found, 5);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t6_hold_valid", psum_valid, 1);
            chk("t6_hold_done", done, 0);
            chk("t6_hold_psum0", lane(0), 10);
        end
        psum_ready = 1'b1;
        @(negedge clk);
        chk("t6_done", done, 1);
        chk("t6_valid_drop", psum_valid, 0);
        @(negedge clk);
        chk("t6_done_pulse", done, 0);

        // Reset in the middle of a stream, then a clean job.
        start = 1'b1;
        len = 8'd10;
        mode_in = 2'd3;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("t7_busy", busy, 0);
        chk("t7_done", done, 0);
        chk("t7_ready_bits", {w_ready, px_ready, pe_en, psum_valid}, 0);
        chk("t7_mode_out", mode_out, 0);
        chk("t7_weight_nz", weight_out != '0, 0);
        chk("t7_psum0", lane(0), 0);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_no_done", done, 0);
        set_prod(0, 7);
        run_job(4, 2'd2, '1, 1'b0, 0, 40, d, b, w);
        chk("t7_done_at", d, 8);
        chk("t7_psum0_new", lane(0), 28);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
